// File: rtl/spi_seq_pkg.sv
// spi_tx_sequencer shared types: FSM state encoding and default
// parameter values used by the sequencer top and its FIFO.
package spi_seq_pkg;

   localparam int DEF_DEPTH         = 8;
   localparam int DEF_ADDR_W        = 3;
   localparam int DEF_STROBE_LEN    = 2;
   localparam int DEF_GAP_LEN       = 2;
   localparam int DEF_START_TIMEOUT = 15;

   // Shared phase counter width; covers strobe, gap and timeout.
   localparam int CNT_W = 8;

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_STROBE     = 3'd1,
      S_WAIT_START = 3'd2,
      S_WAIT_DONE  = 3'd3,
      S_GAP        = 3'd4
   } seq_state_e;

endpackage

// File: rtl/spi_tx_sequencer_if.sv
// Sequencer <-> spi_dma link: start strobe (active low), data byte,
// frame chip select, and status_dmago back from spi_dma.
interface spi_tx_sequencer_if;

   logic       spi_start_n;
   logic [7:0] spi_data;
   logic       spi_cs_n;
   logic       spi_dmago;

   modport master (
      output spi_start_n,
      output spi_data,
      output spi_cs_n,
      input  spi_dmago
   );

   modport slave (
      input  spi_start_n,
      input  spi_data,
      input  spi_cs_n,
      output spi_dmago
   );

endinterface

// File: rtl/spi_seq_fifo.sv
// Byte FIFO for spi_tx_sequencer.
// Ports: clock/sysrst, push_req+wdata, pop, flush; rdata is the head
// byte; level/full/empty/overflow are registered status.
module spi_seq_fifo
   import spi_seq_pkg::*;
#(
   parameter int DEPTH  = DEF_DEPTH,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clock,
   input  logic              sysrst,
   input  logic              push_req,
   input  logic [7:0]        wdata,
   input  logic              pop,
   input  logic              flush,
   output logic [7:0]        rdata,
   output logic [ADDR_W:0]   level,
   output logic              full,
   output logic              empty,
   output logic              overflow
);

   localparam int LVL_W = ADDR_W + 1;
   localparam logic [ADDR_W:0] LVL_FULL = LVL_W'(DEPTH);
   localparam logic [ADDR_W:0] LVL_ONE  = LVL_W'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

   logic [7:0]        mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   lvl_nxt;
   logic              push;

   // A full FIFO still accepts a byte when the head leaves this cycle.
   assign push  = push_req && (!full || pop);
   assign rdata = mem[rd_ptr];

   always_comb begin
      lvl_nxt = level;
      if (push && !pop)
         lvl_nxt = level + LVL_ONE;
      else if (pop && !push)
         lvl_nxt = level - LVL_ONE;
   end

   always_ff @(posedge clock) begin
      if (push)
         mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clock) begin
      if (sysrst || flush) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         full     <= 1'b0;
         empty    <= 1'b1;
         overflow <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)
            rd_ptr <= rd_ptr + PTR_ONE;
         level <= lvl_nxt;
         full  <= (lvl_nxt == LVL_FULL);
         empty <= (lvl_nxt == '0);
         if (push_req && full && !pop)
            overflow <= 1'b1;
      end
   end

endmodule

// File: rtl/spi_tx_sequencer.sv
// Feeds buffered CPU bytes to spi_dma one start strobe at a time,
// paced by status_dmago, with burst chip-select framing.
// Ports: clock/sysrst; cpu_we/cpu_wdata push; flush; enable;
// FIFO status; busy/done_pulse; sticky errors; bus = spi_dma link.
module spi_tx_sequencer
   import spi_seq_pkg::*;
#(
   parameter int DEPTH         = DEF_DEPTH,
   parameter int ADDR_W        = DEF_ADDR_W,
   parameter int STROBE_LEN    = DEF_STROBE_LEN,
   parameter int GAP_LEN       = DEF_GAP_LEN,
   parameter int START_TIMEOUT = DEF_START_TIMEOUT
) (
   input  logic               clock,
   input  logic               sysrst,
   input  logic               cpu_we,
   input  logic [7:0]         cpu_wdata,
   input  logic               flush,
   input  logic               enable,
   output logic [ADDR_W:0]    fifo_level,
   output logic               fifo_full,
   output logic               fifo_empty,
   output logic               busy,
   output logic               done_pulse,
   output logic               overflow_err,
   output logic               timeout_err,
   spi_tx_sequencer_if.master bus
);

   localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STROBE_LEN - 1);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(START_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   seq_state_e       state;
   logic [CNT_W-1:0] cnt;
   logic             pop;
   logic [7:0]       head;

   assign pop = (state == S_IDLE) && enable && !fifo_empty;

   spi_seq_fifo #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_fifo (
      .clock    (clock),
      .sysrst   (sysrst),
      .push_req (cpu_we),
      .wdata    (cpu_wdata),
      .pop      (pop),
      .flush    (flush),
      .rdata    (head),
      .level    (fifo_level),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .overflow (overflow_err)
   );

   always_ff @(posedge clock) begin
      if (sysrst) begin
         state           <= S_IDLE;
         cnt             <= '0;
         bus.spi_start_n <= 1'b1;
         bus.spi_data    <= 8'h00;
         bus.spi_cs_n    <= 1'b1;
         busy            <= 1'b0;
         done_pulse      <= 1'b0;
         timeout_err     <= 1'b0;
      end else begin
         done_pulse <= 1'b0;
         if (flush)
            timeout_err <= 1'b0;
         unique case (state)
            S_IDLE: begin
               // spi_dma loads while start is low, so data and
               // strobe must change on the same edge.
               if (pop) begin
                  bus.spi_data    <= head;
                  bus.spi_start_n <= 1'b0;
                  bus.spi_cs_n    <= 1'b0;
                  busy            <= 1'b1;
                  cnt             <= '0;
                  state           <= S_STROBE;
               end
            end
            S_STROBE: begin
               if (cnt == STB_LAST) begin
                  bus.spi_start_n <= 1'b1;
                  cnt             <= '0;
                  state           <= S_WAIT_START;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            S_WAIT_START: begin
               if (bus.spi_dmago) begin
                  state <= S_WAIT_DONE;
               end else if (cnt == TO_LAST) begin
                  timeout_err <= 1'b1;
                  cnt         <= '0;
                  state       <= S_GAP;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            S_WAIT_DONE: begin
               if (!bus.spi_dmago) begin
                  done_pulse <= 1'b1;
                  cnt        <= '0;
                  state      <= S_GAP;
               end
            end
            S_GAP: begin
               if (GAP_LEN <= 1 || cnt == GAP_LAST) begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
                  // Keep the frame open while more bytes will follow.
                  if (fifo_empty || !enable)
                     bus.spi_cs_n <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_tx_sequencer.sv
// Self-checking bench for spi_tx_sequencer with a behavioural spi_dma
// responder and an event monitor feeding per-scenario checks.
module tb_spi_tx_sequencer;

   localparam int DEPTH         = 8;
   localparam int ADDR_W        = 3;
   localparam int STROBE_LEN    = 2;
   localparam int GAP_LEN       = 2;
   localparam int START_TIMEOUT = 15;

   logic              clock = 1'b0;
   logic              sysrst = 1'b1;
   logic              cpu_we = 1'b0;
   logic [7:0]        cpu_wdata = 8'h00;
   logic              flush = 1'b0;
   logic              enable = 1'b0;
   logic [ADDR_W:0]   fifo_level;
   logic              fifo_full;
   logic              fifo_empty;
   logic              busy;
   logic              done_pulse;
   logic              overflow_err;
   logic              timeout_err;

   spi_tx_sequencer_if bus ();

   spi_tx_sequencer #(
      .DEPTH         (DEPTH),
      .ADDR_W        (ADDR_W),
      .STROBE_LEN    (STROBE_LEN),
      .GAP_LEN       (GAP_LEN),
      .START_TIMEOUT (START_TIMEOUT)
   ) dut (
      .clock        (clock),
      .sysrst       (sysrst),
      .cpu_we       (cpu_we),
      .cpu_wdata    (cpu_wdata),
      .flush        (flush),
      .enable       (enable),
      .fifo_level   (fifo_level),
      .fifo_full    (fifo_full),
      .fifo_empty   (fifo_empty),
      .busy         (busy),
      .done_pulse   (done_pulse),
      .overflow_err (overflow_err),
      .timeout_err  (timeout_err),
      .bus          (bus)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // spi_dma responder: dmago rises dma_lat clocks after the start
   // strobe is released and stays high dma_hi clocks.
   logic dma_on = 1'b0;
   int   dma_lat = 2;
   int   dma_hi = 16;
   int   m_dly = 0;
   int   m_hi = 0;
   logic m_prev_sn = 1'b1;

   always @(posedge clock) begin
      m_prev_sn <= bus.spi_start_n;
      if (sysrst || !dma_on) begin
         m_dly <= 0;
         m_hi <= 0;
         bus.spi_dmago <= 1'b0;
      end else if (!m_prev_sn && bus.spi_start_n) begin
         m_dly <= dma_lat;
      end else if (m_dly > 0) begin
         if (m_dly == 1) begin
            bus.spi_dmago <= 1'b1;
            m_hi <= dma_hi;
         end
         m_dly <= m_dly - 1;
      end else if (m_hi > 0) begin
         if (m_hi == 1)
            bus.spi_dmago <= 1'b0;
         m_hi <= m_hi - 1;
      end
   end

   // Event monitor, sampled on the falling edge.
   int         cyc = 0;
   int         n_str = 0;
   int         n_rel = 0;
   int         n_done = 0;
   int         n_csr = 0;
   int         n_to = 0;
   int         to_cyc = 0;
   int         low_len = 0;
   logic [7:0] st_data [256];
   int         st_cyc [256];
   int         st_len [256];
   int         rel_cyc [256];
   int         d_cyc [256];
   logic       p_sn = 1'b1;
   logic       p_cs = 1'b1;
   logic       p_to = 1'b0;

   always @(negedge clock) begin
      cyc = cyc + 1;
      if (!bus.spi_start_n && p_sn) begin
         st_data[n_str % 256] = bus.spi_data;
         st_cyc[n_str % 256] = cyc;
         n_str = n_str + 1;
         low_len = 1;
      end else if (!bus.spi_start_n) begin
         low_len = low_len + 1;
      end
      if (bus.spi_start_n && !p_sn) begin
         st_len[n_rel % 256] = low_len;
         rel_cyc[n_rel % 256] = cyc;
         n_rel = n_rel + 1;
      end
      if (done_pulse === 1'b1) begin
         d_cyc[n_done % 256] = cyc;
         n_done = n_done + 1;
      end
      if (bus.spi_cs_n && !p_cs)
         n_csr = n_csr + 1;
      if (timeout_err && !p_to) begin
         to_cyc = cyc;
         n_to = n_to + 1;
      end
      p_sn = bus.spi_start_n;
      p_cs = bus.spi_cs_n;
      p_to = timeout_err;
   end

   task automatic nstep();
      @(negedge clock);
      #1;
   endtask

   task automatic steps(input int n);
      repeat (n) nstep();
   endtask

   task automatic push(input logic [7:0] d);
      cpu_we = 1'b1;
      cpu_wdata = d;
      nstep();
      cpu_we = 1'b0;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      nstep();
      flush = 1'b0;
   endtask

   task automatic test_reset();
      sysrst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cpu_we = ~cpu_we;
         cpu_wdata = 8'($urandom);
         nstep();
      end
      cpu_we = 1'b0;
      checks++;
      if (fifo_level !== 4'd0) begin
         errors++;
         $display("FAIL reset_level: got %0d expected 0", fifo_level);
      end
      checks++;
      if (bus.spi_start_n !== 1'b1 || bus.spi_cs_n !== 1'b1) begin
         errors++;
         $display("FAIL reset_spi: got start_n=%b cs_n=%b expected 1 1",
                  bus.spi_start_n, bus.spi_cs_n);
      end
      checks++;
      if (busy !== 1'b0 || done_pulse !== 1'b0 || bus.spi_data !== 8'h00) begin
         errors++;
         $display("FAIL reset_ctl: got busy=%b done=%b data=%h expected 0 0 00",
                  busy, done_pulse, bus.spi_data);
      end
      checks++;
      if (overflow_err !== 1'b0 || timeout_err !== 1'b0 || fifo_empty !== 1'b1) begin
         errors++;
         $display("FAIL reset_flags: got ovf=%b to=%b empty=%b expected 0 0 1",
                  overflow_err, timeout_err, fifo_empty);
      end
      sysrst = 1'b0;
      nstep();
      checks++;
      if (fifo_level !== 4'd0) begin
         errors++;
         $display("FAIL reset_nopush: got %0d expected 0", fifo_level);
      end
   endtask

   task automatic test_single();
      int sb, db, cb;
      logic ok;
      dma_on = 1'b1;
      dma_lat = int'($urandom_range(1, 4));
      dma_hi = int'($urandom_range(2, 16));
      sb = n_str;
      db = n_done;
      cb = n_csr;
      push(8'hA5);
      checks++;
      if (fifo_level !== 4'd1) begin
         errors++;
         $display("FAIL single_level: got %0d expected 1", fifo_level);
      end
      enable = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (n_done > db && !busy) begin
            ok = 1'b1;
            break;
         end
         nstep();
      end
      enable = 1'b0;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL single_timeout: got no completion expected done");
      end
      checks++;
      if (n_str - sb != 1 || st_data[sb % 256] !== 8'hA5) begin
         errors++;
         $display("FAIL single_data: got n=%0d data=%h expected 1 a5",
                  n_str - sb, st_data[sb % 256]);
      end
      checks++;
      if (st_len[sb % 256] != STROBE_LEN) begin
         errors++;
         $display("FAIL single_strobe_len: got %0d expected %0d",
                  st_len[sb % 256], STROBE_LEN);
      end
      checks++;
      if (n_done - db != 1) begin
         errors++;
         $display("FAIL single_done: got %0d expected 1", n_done - db);
      end
      checks++;
      if (bus.spi_cs_n !== 1'b1 || n_csr - cb != 1 || fifo_level !== 4'd0) begin
         errors++;
         $display("FAIL single_end: got cs_n=%b rises=%0d lvl=%0d expected 1 1 0",
                  bus.spi_cs_n, n_csr - cb, fifo_level);
      end
   endtask

   task automatic test_burst();
      logic [7:0] q [$];
      int n, sb, db, cb;
      logic ok;
      dma_on = 1'b1;
      dma_lat = int'($urandom_range(1, 4));
      dma_hi = int'($urandom_range(1, 10));
      n = 3 + int'($urandom_range(0, 3));
      q = {8'h01, 8'h02, 8'h03};
      while (q.size() < n)
         q.push_back(8'($urandom));
      sb = n_str;
      db = n_done;
      cb = n_csr;
      foreach (q[i])
         push(q[i]);
      checks++;
      if (fifo_level !== 4'(n)) begin
         errors++;
         $display("FAIL burst_level: got %0d expected %0d", fifo_level, n);
      end
      enable = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 60 * n; i++) begin
         if (n_done - db >= n && !busy) begin
            ok = 1'b1;
            break;
         end
         nstep();
      end
      enable = 1'b0;
      checks++;
      if (!ok || n_done - db != n || n_str - sb != n) begin
         errors++;
         $display("FAIL burst_count: got done=%0d strobes=%0d expected %0d",
                  n_done - db, n_str - sb, n);
      end
      for (int k = 0; k < n; k++) begin
         checks++;
         if (st_data[(sb + k) % 256] !== q[k] ||
             st_len[(sb + k) % 256] != STROBE_LEN) begin
            errors++;
            $display("FAIL burst_byte%0d: got %h len %0d expected %h len %0d",
                     k, st_data[(sb + k) % 256], st_len[(sb + k) % 256],
                     q[k], STROBE_LEN);
         end
      end
      for (int k = 1; k < n; k++) begin
         checks++;
         if (st_cyc[(sb + k) % 256] - d_cyc[(db + k - 1) % 256] - 1 != GAP_LEN) begin
            errors++;
            $display("FAIL burst_gap%0d: got %0d expected %0d", k,
                     st_cyc[(sb + k) % 256] - d_cyc[(db + k - 1) % 256] - 1,
                     GAP_LEN);
         end
      end
      checks++;
      if (n_csr - cb != 1 || bus.spi_cs_n !== 1'b1 || fifo_level !== 4'd0) begin
         errors++;
         $display("FAIL burst_cs: got rises=%0d cs_n=%b lvl=%0d expected 1 1 0",
                  n_csr - cb, bus.spi_cs_n, fifo_level);
      end
   endtask

   task automatic test_overflow();
      int exp_lvl;
      for (int i = 1; i <= 9; i++) begin
         push(8'($urandom));
         exp_lvl = (i > DEPTH) ? DEPTH : i;
         checks++;
         if (fifo_level !== 4'(exp_lvl)) begin
            errors++;
            $display("FAIL ovf_level%0d: got %0d expected %0d", i, fifo_level, exp_lvl);
         end
         checks++;
         if (fifo_full !== (i >= DEPTH) || overflow_err !== (i > DEPTH)) begin
            errors++;
            $display("FAIL ovf_flags%0d: got full=%b ovf=%b expected %b %b", i,
                     fifo_full, overflow_err, i >= DEPTH, i > DEPTH);
         end
      end
      do_flush();
      checks++;
      if (fifo_level !== 4'd0 || overflow_err !== 1'b0 || fifo_empty !== 1'b1) begin
         errors++;
         $display("FAIL ovf_flush: got lvl=%0d ovf=%b empty=%b expected 0 0 1",
                  fifo_level, overflow_err, fifo_empty);
      end
   endtask

   task automatic test_timeout();
      int rb, db, tb0;
      logic ok;
      dma_on = 1'b0;
      rb = n_rel;
      db = n_done;
      tb0 = n_to;
      push(8'($urandom));
      enable = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (n_to > tb0 && !busy) begin
            ok = 1'b1;
            break;
         end
         nstep();
      end
      enable = 1'b0;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL timeout_wait: got no timeout expected timeout_err");
      end
      checks++;
      if (to_cyc - rel_cyc[rb % 256] != START_TIMEOUT) begin
         errors++;
         $display("FAIL timeout_delay: got %0d expected %0d",
                  to_cyc - rel_cyc[rb % 256], START_TIMEOUT);
      end
      checks++;
      if (n_done != db || busy !== 1'b0 || bus.spi_cs_n !== 1'b1 ||
          timeout_err !== 1'b1) begin
         errors++;
         $display("FAIL timeout_state: got done=%0d busy=%b cs_n=%b to=%b expected 0 0 1 1",
                  n_done - db, busy, bus.spi_cs_n, timeout_err);
      end
      do_flush();
      checks++;
      if (timeout_err !== 1'b0) begin
         errors++;
         $display("FAIL timeout_clear: got %b expected 0", timeout_err);
      end
   endtask

   task automatic test_enable_drop();
      logic [7:0] b0, b1;
      int sb, db;
      logic ok;
      dma_on = 1'b1;
      dma_lat = int'($urandom_range(1, 4));
      dma_hi = int'($urandom_range(2, 8));
      b0 = 8'($urandom);
      b1 = 8'($urandom);
      sb = n_str;
      db = n_done;
      push(b0);
      push(b1);
      enable = 1'b1;
      for (int i = 0; i < 20 && n_str == sb; i++)
         nstep();
      enable = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (n_done > db && !busy) begin
            ok = 1'b1;
            break;
         end
         nstep();
      end
      steps(5);
      checks++;
      if (!ok || n_str - sb != 1 || st_data[sb % 256] !== b0) begin
         errors++;
         $display("FAIL endrop_one: got n=%0d data=%h expected 1 %h",
                  n_str - sb, st_data[sb % 256], b0);
      end
      checks++;
      if (fifo_level !== 4'd1 || bus.spi_cs_n !== 1'b1) begin
         errors++;
         $display("FAIL endrop_hold: got lvl=%0d cs_n=%b expected 1 1",
                  fifo_level, bus.spi_cs_n);
      end
      enable = 1'b1;
      for (int i = 0; i < 200; i++) begin
         if (n_done - db >= 2 && !busy)
            break;
         nstep();
      end
      enable = 1'b0;
      checks++;
      if (n_str - sb != 2 || st_data[(sb + 1) % 256] !== b1 || fifo_level !== 4'd0) begin
         errors++;
         $display("FAIL endrop_resume: got n=%0d data=%h lvl=%0d expected 2 %h 0",
                  n_str - sb, st_data[(sb + 1) % 256], fifo_level, b1);
      end
   endtask

   task automatic test_flush_inflight();
      logic [7:0] q [$];
      int sb, db;
      logic ok;
      dma_on = 1'b1;
      dma_lat = int'($urandom_range(1, 3));
      dma_hi = int'($urandom_range(6, 16));
      sb = n_str;
      db = n_done;
      for (int i = 0; i < 4; i++)
         q.push_back(8'($urandom));
      foreach (q[i])
         push(q[i]);
      enable = 1'b1;
      for (int i = 0; i < 50 && bus.spi_dmago !== 1'b1; i++)
         nstep();
      nstep();
      do_flush();
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (n_done > db && !busy) begin
            ok = 1'b1;
            break;
         end
         nstep();
      end
      steps(20);
      enable = 1'b0;
      checks++;
      if (!ok || n_done - db != 1) begin
         errors++;
         $display("FAIL flush_done: got %0d expected 1", n_done - db);
      end
      checks++;
      if (n_str - sb != 1 || st_data[sb % 256] !== q[0]) begin
         errors++;
         $display("FAIL flush_strobes: got n=%0d data=%h expected 1 %h",
                  n_str - sb, st_data[sb % 256], q[0]);
      end
      checks++;
      if (fifo_level !== 4'd0 || fifo_empty !== 1'b1 || bus.spi_cs_n !== 1'b1) begin
         errors++;
         $display("FAIL flush_state: got lvl=%0d empty=%b cs_n=%b expected 0 1 1",
                  fifo_level, fifo_empty, bus.spi_cs_n);
      end
   endtask

   task automatic test_reset_midbyte();
      logic seen;
      dma_on = 1'b1;
      push(8'($urandom));
      enable = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus.spi_start_n === 1'b0) begin
            seen = 1'b1;
            break;
         end
         nstep();
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL rstmid_strobe: got no strobe expected start_n low");
      end
      sysrst = 1'b1;
      nstep();
      checks++;
      if (bus.spi_start_n !== 1'b1 || bus.spi_cs_n !== 1'b1 || busy !== 1'b0 ||
          fifo_level !== 4'd0) begin
         errors++;
         $display("FAIL rstmid_abort: got start_n=%b cs_n=%b busy=%b lvl=%0d expected 1 1 0 0",
                  bus.spi_start_n, bus.spi_cs_n, busy, fifo_level);
      end
      sysrst = 1'b0;
      enable = 1'b0;
      nstep();
   endtask

   initial begin
      nstep();
      test_reset();
      test_single();
      test_burst();
      test_burst();
      test_overflow();
      test_timeout();
      test_enable_drop();
      test_flush_inflight();
      test_reset_midbyte();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
